qmax_updater: RTL and testbench
===============================

Name: qmax_updater

Overview:
- Read-modify-write engine in front of the per-state Q-max BRAM table.
- Accepts (state, new Q) requests and reads the stored max for that state.
- Writes back max(stored, new) only when the value increases; reports the resulting max downstream.
- Owns table initialisation: a clear sweep after reset and on request, since the BRAM has no reset.

Parameters:
ADDR_WIDTH, 6, state index width; must satisfy 2^ADDR_WIDTH >= DEPTH
DATA_WIDTH, 8, Q value width, two's-complement signed
DEPTH, 64, number of states/table entries
CLEAR_VAL, 0, value written to every entry during a clear sweep
CNT_WIDTH, 16, width of the update statistics counter

Ports:
i_clk  in  1  clock; all logic on rising edge
i_rst_n  in  1  asynchronous active-low reset
i_req_valid  in  1  update request valid
i_req_state  in  ADDR_WIDTH  state index
i_req_q  in  DATA_WIDTH  candidate Q value (signed)
o_req_ready  out  1  request accepted when valid&ready
i_clear  in  1  single-cycle pulse: re-initialise table
o_addr_r  out  ADDR_WIDTH  table read address (combinational = i_req_state)
i_qmax_rdata  in  DATA_WIDTH  table read data, 1-cycle registered latency
o_addr_w  out  ADDR_WIDTH  table write address (registered)
o_write_en  out  1  table write enable (registered)
o_data  out  DATA_WIDTH  table write data (registered)
o_upd_valid  out  1  result pulse
o_upd_state  out  ADDR_WIDTH  state of result
o_upd_max  out  DATA_WIDTH  resulting max for that state
o_upd_changed  out  1  entry was increased
o_upd_cnt  out  CNT_WIDTH  count of changed writes, saturating
o_busy  out  1  clear sweep in progress or pending

Behaviour:
- Reset (async assert, sync release): all outputs and pipeline valids 0, forwarding entries invalid, counter 0; FSM enters CLEAR with sweep address 0.
- FSM states: CLEAR, DRAIN, RUN.
  - CLEAR: o_req_ready=0, o_busy=1. Each cycle writes CLEAR_VAL to sweep addr via registered write port; addr 0..DEPTH-1, one per cycle; after DEPTH writes -> RUN.
  - RUN: o_req_ready=1 (full throughput, 1 req/cycle). An i_clear pulse -> DRAIN.
  - DRAIN: o_req_ready=0, o_busy=1; waits until stage1 and stage2 are empty -> CLEAR. On entering CLEAR: o_upd_cnt cleared, forwarding entries invalidated.
- i_clear in CLEAR or DRAIN is ignored. Reset mid-sweep restarts the sweep at address 0.
- Pipeline (request accepted cycle t):
  - t+1, stage1: {state, q} registered; i_qmax_rdata valid; compare computed.
  - t+2, stage2 registered outputs: o_upd_valid=1, o_upd_state, o_upd_max, o_upd_changed. If changed, o_write_en=1, o_addr_w=state, o_data=new max; the table is written at the end of t+2.
- Hazard forwarding:
  - Table read-during-write on the same edge returns old data, so two in-flight results can be stale.
  - Stage1 stored value = stage2 max if stage2 valid and its state matches; else wb max if wb valid and matches; else i_qmax_rdata.
  - wb = stage2 contents delayed one cycle. Stage2 has priority over wb.
  - Forward regardless of whether stage2/wb actually wrote.
- Compare: signed. changed = new_q > stored; equal is not a change. max = changed ? new_q : stored.
- o_upd_cnt increments on each changed write and holds at all-ones.
- No downstream backpressure; o_upd_* are single-cycle pulses.

Decomposition:
- Shared package qlearn_pkg: DATA_WIDTH/ADDR_WIDTH/DEPTH defaults, q_t signed typedef, state_t typedef, FSM state enum (CLEAR/DRAIN/RUN).
- One natural sub-module: qmax_fwd_cmp (combinational forwarding mux + signed compare), instantiated in stage1.
- Table instance stays outside; the top level wires o_addr_r/o_addr_w/o_write_en/o_data and i_qmax_rdata to it.

Test Plan:
- Reset release -> o_req_ready=0, o_busy=1 for exactly 64 cycles; writes of 0 to addr 0..63 in order; then o_req_ready=1.
- Request state 5, q=10 -> two cycles later o_upd_max=10, changed=1, write 10 to addr 5; then q=7 for state 5 -> max=10, changed=0, no write.
- Back-to-back state 3 with q=4,9,6,12 (consecutive cycles) -> maxes 4,9,9,12; writes 4,9,12; o_upd_cnt +3. Exercises stage2 and wb forwarding.
- Signed compare: state 1 q=-3 after clear -> max=0, changed=0; q=127 -> changed=1; q=-128 -> max=127.
- i_clear with two requests in flight -> both complete; o_req_ready held low through drain + 64-cycle sweep; o_upd_cnt=0 afterwards; state 5 reads 0.
- Reset asserted mid-sweep at addr 20 -> outputs 0 immediately; after release the sweep restarts at 0 and runs the full 64 cycles.

Source files
------------

// File: rtl/qlearn_pkg.sv
// Shared Q-learning definitions.
// Default table geometry, Q/state typedefs and the Q-max updater FSM encoding.
package qlearn_pkg;

    localparam int unsigned QL_ADDR_WIDTH = 6;
    localparam int unsigned QL_DATA_WIDTH = 8;
    localparam int unsigned QL_DEPTH      = 64;

    typedef logic signed [QL_DATA_WIDTH-1:0] q_t;
    typedef logic        [QL_ADDR_WIDTH-1:0] state_t;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        DRAIN = 2'd1,
        RUN   = 2'd2
    } fsm_state_t;

endpackage

// File: rtl/qmax_fwd_cmp.sv
// Forwarding mux and signed compare for the Q-max read-modify-write pipeline.
// Ports:
//   i_state, i_new_q           : request in stage1
//   i_rdata                    : stored value read from the table
//   i_s2_valid/state/max       : result currently in stage2 (highest priority)
//   i_wb_valid/state/max       : stage2 result delayed one cycle
//   o_max, o_changed           : resulting max and "strictly increased" flag
module qmax_fwd_cmp #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 8
) (
    input  logic [ADDR_WIDTH-1:0] i_state,
    input  logic [DATA_WIDTH-1:0] i_new_q,
    input  logic [DATA_WIDTH-1:0] i_rdata,
    input  logic                  i_s2_valid,
    input  logic [ADDR_WIDTH-1:0] i_s2_state,
    input  logic [DATA_WIDTH-1:0] i_s2_max,
    input  logic                  i_wb_valid,
    input  logic [ADDR_WIDTH-1:0] i_wb_state,
    input  logic [DATA_WIDTH-1:0] i_wb_max,
    output logic [DATA_WIDTH-1:0] o_max,
    output logic                  o_changed
);

    logic signed [DATA_WIDTH-1:0] w_stored;
    logic signed [DATA_WIDTH-1:0] w_new;

    // The table returns old data on read-during-write, so the two most recent
    // results may not be visible in i_rdata yet; the younger one wins.
    always_comb begin
        if (i_s2_valid && (i_s2_state == i_state)) begin
            w_stored = i_s2_max;
        end else if (i_wb_valid && (i_wb_state == i_state)) begin
            w_stored = i_wb_max;
        end else begin
            w_stored = i_rdata;
        end
    end

    assign w_new     = i_new_q;
    assign o_changed = (w_new > w_stored);
    assign o_max     = o_changed ? w_new : w_stored;

endmodule

// File: rtl/qmax_updater.sv
// Read-modify-write engine in front of the per-state Q-max table.
// Accepts (state, q) requests, writes back max(stored, q) only when it grows,
// reports each result downstream and sweeps the table to CLEAR_VAL after reset
// or on i_clear.
// Ports:
//   i_clk, i_rst_n                     : clock, async active-low reset
//   i_req_valid/state/q, o_req_ready   : update request handshake
//   i_clear                            : pulse to re-initialise the table
//   o_addr_r, i_qmax_rdata             : table read port (1-cycle latency)
//   o_addr_w, o_write_en, o_data       : table write port (registered)
//   o_upd_valid/state/max/changed      : single-cycle result pulse
//   o_upd_cnt                          : saturating count of changed writes
//   o_busy                             : clear sweep in progress or pending
module qmax_updater
    import qlearn_pkg::*;
#(
    parameter int ADDR_WIDTH = QL_ADDR_WIDTH,
    parameter int DATA_WIDTH = QL_DATA_WIDTH,
    parameter int DEPTH      = QL_DEPTH,
    parameter int CLEAR_VAL  = 0,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_req_valid,
    input  logic [ADDR_WIDTH-1:0] i_req_state,
    input  logic [DATA_WIDTH-1:0] i_req_q,
    output logic                  o_req_ready,
    input  logic                  i_clear,
    output logic [ADDR_WIDTH-1:0] o_addr_r,
    input  logic [DATA_WIDTH-1:0] i_qmax_rdata,
    output logic [ADDR_WIDTH-1:0] o_addr_w,
    output logic                  o_write_en,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_upd_valid,
    output logic [ADDR_WIDTH-1:0] o_upd_state,
    output logic [DATA_WIDTH-1:0] o_upd_max,
    output logic                  o_upd_changed,
    output logic [CNT_WIDTH-1:0]  o_upd_cnt,
    output logic                  o_busy
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [DATA_WIDTH-1:0] CLR_DATA  = DATA_WIDTH'(CLEAR_VAL);

    fsm_state_t            r_state;
    fsm_state_t            w_next_state;
    logic [ADDR_WIDTH-1:0] r_sweep_addr;
    logic                  w_accept;
    logic                  w_enter_clear;

    logic                  r_s1_valid;
    logic [ADDR_WIDTH-1:0] r_s1_state;
    logic [DATA_WIDTH-1:0] r_s1_q;

    logic                  r_wb_valid;
    logic [ADDR_WIDTH-1:0] r_wb_state;
    logic [DATA_WIDTH-1:0] r_wb_max;

    logic [DATA_WIDTH-1:0] w_max;
    logic                  w_changed;

    // ---------------- FSM ----------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= CLEAR;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            CLEAR:   if (r_sweep_addr == LAST_ADDR) w_next_state = RUN;
            DRAIN:   if (!r_s1_valid && !o_upd_valid) w_next_state = CLEAR;
            RUN:     if (i_clear) w_next_state = DRAIN;
            default: w_next_state = CLEAR;
        endcase
    end

    always_comb begin
        o_req_ready = 1'b0;
        o_busy      = 1'b1;
        if (r_state == RUN) begin
            o_req_ready = 1'b1;
            o_busy      = 1'b0;
        end
    end

    assign w_enter_clear = (r_state == DRAIN) && (w_next_state == CLEAR);
    assign w_accept      = i_req_valid && o_req_ready;
    assign o_addr_r      = i_req_state;

    // Sweep address rests at 0 outside CLEAR so every sweep starts from entry 0.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sweep_addr <= '0;
        end else if (r_state == CLEAR) begin
            r_sweep_addr <= r_sweep_addr + ADDR_WIDTH'(1);
        end else begin
            r_sweep_addr <= '0;
        end
    end

    // ---------------- Stage 1 ----------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_state <= '0;
            r_s1_q     <= '0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_state <= i_req_state;
                r_s1_q     <= i_req_q;
            end
        end
    end

    qmax_fwd_cmp #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_fwd_cmp (
        .i_state    (r_s1_state),
        .i_new_q    (r_s1_q),
        .i_rdata    (i_qmax_rdata),
        .i_s2_valid (o_upd_valid),
        .i_s2_state (o_upd_state),
        .i_s2_max   (o_upd_max),
        .i_wb_valid (r_wb_valid),
        .i_wb_state (r_wb_state),
        .i_wb_max   (r_wb_max),
        .o_max      (w_max),
        .o_changed  (w_changed)
    );

    // ---------------- Stage 2, write port, write-back history ----------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_upd_valid   <= 1'b0;
            o_upd_state   <= '0;
            o_upd_max     <= '0;
            o_upd_changed <= 1'b0;
            o_write_en    <= 1'b0;
            o_addr_w      <= '0;
            o_data        <= '0;
            r_wb_valid    <= 1'b0;
            r_wb_state    <= '0;
            r_wb_max      <= '0;
            o_upd_cnt     <= '0;
        end else begin
            o_upd_valid   <= r_s1_valid;
            o_upd_changed <= r_s1_valid && w_changed;
            if (r_s1_valid) begin
                o_upd_state <= r_s1_state;
                o_upd_max   <= w_max;
            end

            // Stage1 is always empty while sweeping, so the port is never shared.
            if (r_state == CLEAR) begin
                o_write_en <= 1'b1;
                o_addr_w   <= r_sweep_addr;
                o_data     <= CLR_DATA;
            end else begin
                o_write_en <= r_s1_valid && w_changed;
                o_addr_w   <= r_s1_state;
                o_data     <= w_max;
            end

            r_wb_valid <= o_upd_valid && !w_enter_clear;
            r_wb_state <= o_upd_state;
            r_wb_max   <= o_upd_max;

            if (w_enter_clear) begin
                o_upd_cnt <= '0;
            end else if (r_s1_valid && w_changed && (o_upd_cnt != '1)) begin
                o_upd_cnt <= o_upd_cnt + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_qmax_updater.sv
module tb_qmax_updater;

    localparam int AW    = 6;
    localparam int DW    = 8;
    localparam int DEPTH = 64;
    localparam int CW    = 16;

    logic          i_clk = 1'b0;
    logic          i_rst_n = 1'b0;
    logic          i_req_valid = 1'b0;
    logic [AW-1:0] i_req_state = '0;
    logic [DW-1:0] i_req_q = '0;
    logic          i_clear = 1'b0;
    logic [DW-1:0] i_qmax_rdata;
    logic          o_req_ready;
    logic [AW-1:0] o_addr_r;
    logic [AW-1:0] o_addr_w;
    logic          o_write_en;
    logic [DW-1:0] o_data;
    logic          o_upd_valid;
    logic [AW-1:0] o_upd_state;
    logic [DW-1:0] o_upd_max;
    logic          o_upd_changed;
    logic [CW-1:0] o_upd_cnt;
    logic          o_busy;

    logic [DW-1:0] mem [DEPTH];

    int n_assert = 0;
    int n_fail   = 0;

    always #5 i_clk = ~i_clk;

    // Table model: registered read, old data on read-during-write.
    always @(posedge i_clk) begin
        i_qmax_rdata <= mem[o_addr_r];
        if (o_write_en) mem[o_addr_w] <= o_data;
    end

    qmax_updater #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .DEPTH     (DEPTH),
        .CLEAR_VAL (0),
        .CNT_WIDTH (CW)
    ) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_req_valid  (i_req_valid),
        .i_req_state  (i_req_state),
        .i_req_q      (i_req_q),
        .o_req_ready  (o_req_ready),
        .i_clear      (i_clear),
        .o_addr_r     (o_addr_r),
        .i_qmax_rdata (i_qmax_rdata),
        .o_addr_w     (o_addr_w),
        .o_write_en   (o_write_en),
        .o_data       (o_data),
        .o_upd_valid  (o_upd_valid),
        .o_upd_state  (o_upd_state),
        .o_upd_max    (o_upd_max),
        .o_upd_changed(o_upd_changed),
        .o_upd_cnt    (o_upd_cnt),
        .o_busy       (o_busy)
    );

    // Single request; returns at the negedge where its result is in stage2.
    task automatic do_req(input int st, input int q);
        @(posedge i_clk); #1;
        i_req_valid = 1'b1; i_req_state = AW'(st); i_req_q = DW'(q);
        @(posedge i_clk); #1;
        i_req_valid = 1'b0;
        @(posedge i_clk);
        @(negedge i_clk);
    endtask

    task automatic test_reset();
        int busy_cyc, n_wr;
        bit done;
        i_rst_n = 1'b0;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        n_assert++; if (o_req_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %b expected 0", o_req_ready); end
        n_assert++; if (o_busy !== 1'b1) begin n_fail++; $display("FAIL rst_busy: got %b expected 1", o_busy); end
        n_assert++; if (o_write_en !== 1'b0) begin n_fail++; $display("FAIL rst_wen: got %b expected 0", o_write_en); end
        n_assert++; if (o_upd_valid !== 1'b0) begin n_fail++; $display("FAIL rst_uvalid: got %b expected 0", o_upd_valid); end
        n_assert++; if (o_upd_cnt !== '0) begin n_fail++; $display("FAIL rst_cnt: got %0d expected 0", o_upd_cnt); end
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        busy_cyc = 0; n_wr = 0; done = 1'b0;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge i_clk);
            if (o_write_en) begin
                n_assert++;
                if (o_addr_w !== AW'(n_wr) || o_data !== '0) begin
                    n_fail++; $display("FAIL sweep_write: got addr %0d data %0d expected addr %0d data 0", o_addr_w, o_data, n_wr);
                end
                n_wr++;
            end
            if (o_busy) busy_cyc++; else done = 1'b1;
        end
        n_assert++; if (!done) begin n_fail++; $display("FAIL sweep_timeout: busy still high after 200 cycles"); end
        n_assert++; if (busy_cyc != 64) begin n_fail++; $display("FAIL sweep_busy_cycles: got %0d expected 64", busy_cyc); end
        n_assert++; if (n_wr != 64) begin n_fail++; $display("FAIL sweep_writes: got %0d expected 64", n_wr); end
        n_assert++; if (o_req_ready !== 1'b1) begin n_fail++; $display("FAIL sweep_ready_after: got %b expected 1", o_req_ready); end
    endtask

    task automatic test_basic();
        do_req(5, 10);
        n_assert++; if (o_upd_valid !== 1'b1) begin n_fail++; $display("FAIL basic1_valid: got %b expected 1", o_upd_valid); end
        n_assert++; if (o_upd_state !== 6'd5) begin n_fail++; $display("FAIL basic1_state: got %0d expected 5", o_upd_state); end
        n_assert++; if (o_upd_max !== 8'd10) begin n_fail++; $display("FAIL basic1_max: got %0d expected 10", o_upd_max); end
        n_assert++; if (o_upd_changed !== 1'b1) begin n_fail++; $display("FAIL basic1_changed: got %b expected 1", o_upd_changed); end
        n_assert++; if (o_write_en !== 1'b1 || o_addr_w !== 6'd5 || o_data !== 8'd10) begin
            n_fail++; $display("FAIL basic1_write: got en %b addr %0d data %0d expected en 1 addr 5 data 10", o_write_en, o_addr_w, o_data);
        end
        n_assert++; if (o_upd_cnt !== 16'd1) begin n_fail++; $display("FAIL basic1_cnt: got %0d expected 1", o_upd_cnt); end
        @(negedge i_clk);
        n_assert++; if (o_upd_valid !== 1'b0) begin n_fail++; $display("FAIL basic_pulse: got %b expected 0", o_upd_valid); end
        do_req(5, 7);
        n_assert++; if (o_upd_max !== 8'd10) begin n_fail++; $display("FAIL basic2_max: got %0d expected 10", o_upd_max); end
        n_assert++; if (o_upd_changed !== 1'b0) begin n_fail++; $display("FAIL basic2_changed: got %b expected 0", o_upd_changed); end
        n_assert++; if (o_write_en !== 1'b0) begin n_fail++; $display("FAIL basic2_wen: got %b expected 0", o_write_en); end
        n_assert++; if (o_upd_cnt !== 16'd1) begin n_fail++; $display("FAIL basic2_cnt: got %0d expected 1", o_upd_cnt); end
    endtask

    // Consecutive requests; result j is visible at the negedge of iteration j+2.
    task automatic test_back_to_back();
        int qs[4]     = '{4, 9, 6, 12};
        int exp_mx[4] = '{4, 9, 9, 12};
        bit exp_ch[4] = '{1, 1, 0, 1};
        int j;
        for (int i = 0; i < 6; i++) begin
            @(posedge i_clk); #1;
            if (i < 4) begin i_req_valid = 1'b1; i_req_state = 6'd3; i_req_q = DW'(qs[i]); end
            else i_req_valid = 1'b0;
            @(negedge i_clk);
            if (i >= 2) begin
                j = i - 2;
                n_assert++; if (o_upd_valid !== 1'b1 || o_upd_max !== DW'(exp_mx[j]) || o_upd_changed !== exp_ch[j]) begin
                    n_fail++; $display("FAIL b2b_result[%0d]: got v %b max %0d ch %b expected v 1 max %0d ch %b", j, o_upd_valid, o_upd_max, o_upd_changed, exp_mx[j], exp_ch[j]);
                end
                n_assert++; if (o_write_en !== exp_ch[j] || (exp_ch[j] && o_data !== DW'(exp_mx[j]))) begin
                    n_fail++; $display("FAIL b2b_write[%0d]: got en %b data %0d expected en %b data %0d", j, o_write_en, o_data, exp_ch[j], exp_mx[j]);
                end
            end
        end
        n_assert++; if (o_upd_cnt !== 16'd4) begin n_fail++; $display("FAIL b2b_cnt: got %0d expected 4", o_upd_cnt); end
    endtask

    // Third request hits a stale table read that only the write-back entry covers.
    task automatic test_wb_forward();
        int sts[3]    = '{7, 8, 7};
        int qs[3]     = '{5, 1, 3};
        int exp_mx[3] = '{5, 1, 5};
        bit exp_ch[3] = '{1, 1, 0};
        int j;
        for (int i = 0; i < 5; i++) begin
            @(posedge i_clk); #1;
            if (i < 3) begin i_req_valid = 1'b1; i_req_state = AW'(sts[i]); i_req_q = DW'(qs[i]); end
            else i_req_valid = 1'b0;
            @(negedge i_clk);
            if (i >= 2) begin
                j = i - 2;
                n_assert++; if (o_upd_state !== AW'(sts[j]) || o_upd_max !== DW'(exp_mx[j]) || o_upd_changed !== exp_ch[j]) begin
                    n_fail++; $display("FAIL wb_result[%0d]: got st %0d max %0d ch %b expected st %0d max %0d ch %b", j, o_upd_state, o_upd_max, o_upd_changed, sts[j], exp_mx[j], exp_ch[j]);
                end
            end
        end
        n_assert++; if (o_upd_cnt !== 16'd6) begin n_fail++; $display("FAIL wb_cnt: got %0d expected 6", o_upd_cnt); end
    endtask

    task automatic test_signed();
        do_req(1, -3);
        n_assert++; if (o_upd_max !== 8'd0 || o_upd_changed !== 1'b0) begin
            n_fail++; $display("FAIL signed_neg: got max %0d ch %b expected max 0 ch 0", $signed(o_upd_max), o_upd_changed);
        end
        do_req(1, 127);
        n_assert++; if (o_upd_max !== 8'd127 || o_upd_changed !== 1'b1) begin
            n_fail++; $display("FAIL signed_127: got max %0d ch %b expected max 127 ch 1", $signed(o_upd_max), o_upd_changed);
        end
        do_req(1, -128);
        n_assert++; if (o_upd_max !== 8'd127 || o_upd_changed !== 1'b0 || o_write_en !== 1'b0) begin
            n_fail++; $display("FAIL signed_m128: got max %0d ch %b en %b expected max 127 ch 0 en 0", $signed(o_upd_max), o_upd_changed, o_write_en);
        end
        n_assert++; if (o_upd_cnt !== 16'd7) begin n_fail++; $display("FAIL signed_cnt: got %0d expected 7", o_upd_cnt); end
    endtask

    task automatic test_clear_inflight();
        int low, n_wr;
        bit done;
        @(posedge i_clk); #1;
        i_req_valid = 1'b1; i_req_state = 6'd5; i_req_q = 8'd20;
        @(posedge i_clk); #1;
        i_req_state = 6'd9; i_req_q = 8'd3; i_clear = 1'b1;
        @(posedge i_clk); #1;
        i_req_valid = 1'b0; i_clear = 1'b0;
        @(negedge i_clk);
        low = 0;
        if (!o_req_ready) low++;
        n_assert++; if (o_upd_valid !== 1'b1 || o_upd_state !== 6'd5 || o_upd_max !== 8'd20 || o_upd_changed !== 1'b1) begin
            n_fail++; $display("FAIL clr_inflight_a: got v %b st %0d max %0d ch %b expected v 1 st 5 max 20 ch 1", o_upd_valid, o_upd_state, o_upd_max, o_upd_changed);
        end
        @(posedge i_clk); #1;
        i_clear = 1'b1;
        @(negedge i_clk);
        if (!o_req_ready) low++;
        n_assert++; if (o_upd_valid !== 1'b1 || o_upd_state !== 6'd9 || o_upd_max !== 8'd3 || o_upd_changed !== 1'b1) begin
            n_fail++; $display("FAIL clr_inflight_b: got v %b st %0d max %0d ch %b expected v 1 st 9 max 3 ch 1", o_upd_valid, o_upd_state, o_upd_max, o_upd_changed);
        end
        n_assert++; if (o_upd_cnt !== 16'd9) begin n_fail++; $display("FAIL clr_cnt_before: got %0d expected 9", o_upd_cnt); end
        n_wr = 0; done = 1'b0;
        for (int k = 0; k < 200 && !done; k++) begin
            @(posedge i_clk); #1;
            i_clear = (k == 20);
            @(negedge i_clk);
            if (o_write_en && o_data === '0) begin
                n_assert++;
                if (o_addr_w !== AW'(n_wr)) begin n_fail++; $display("FAIL clr_sweep_addr: got %0d expected %0d", o_addr_w, n_wr); end
                n_wr++;
            end
            if (o_req_ready) done = 1'b1; else low++;
        end
        i_clear = 1'b0;
        n_assert++; if (!done) begin n_fail++; $display("FAIL clr_timeout: ready still low after 200 cycles"); end
        n_assert++; if (low != 67) begin n_fail++; $display("FAIL clr_ready_low_cycles: got %0d expected 67", low); end
        n_assert++; if (n_wr != 64) begin n_fail++; $display("FAIL clr_sweep_writes: got %0d expected 64", n_wr); end
        n_assert++; if (o_upd_cnt !== '0) begin n_fail++; $display("FAIL clr_cnt_after: got %0d expected 0", o_upd_cnt); end
        do_req(5, -1);
        n_assert++; if (o_upd_max !== 8'd0 || o_upd_changed !== 1'b0) begin
            n_fail++; $display("FAIL clr_state5: got max %0d ch %b expected max 0 ch 0", $signed(o_upd_max), o_upd_changed);
        end
        do_req(9, 1);
        n_assert++; if (o_upd_max !== 8'd1 || o_upd_changed !== 1'b1 || o_upd_cnt !== 16'd1) begin
            n_fail++; $display("FAIL clr_restart: got max %0d ch %b cnt %0d expected max 1 ch 1 cnt 1", o_upd_max, o_upd_changed, o_upd_cnt);
        end
    endtask

    task automatic test_reset_mid_sweep();
        int busy_cyc, n_wr;
        bit found, done;
        @(posedge i_clk); #1;
        i_clear = 1'b1;
        @(posedge i_clk); #1;
        i_clear = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 200 && !found; k++) begin
            @(negedge i_clk);
            if (o_write_en && o_addr_w === 6'd20) found = 1'b1;
        end
        n_assert++; if (!found) begin n_fail++; $display("FAIL mid_find_addr20: sweep write to 20 not seen"); end
        i_rst_n = 1'b0;
        #1;
        n_assert++; if (o_write_en !== 1'b0 || o_addr_w !== '0 || o_data !== '0) begin
            n_fail++; $display("FAIL mid_rst_write: got en %b addr %0d data %0d expected all 0", o_write_en, o_addr_w, o_data);
        end
        n_assert++; if (o_upd_valid !== 1'b0 || o_upd_cnt !== '0 || o_req_ready !== 1'b0 || o_busy !== 1'b1) begin
            n_fail++; $display("FAIL mid_rst_status: got v %b cnt %0d rdy %b busy %b expected v 0 cnt 0 rdy 0 busy 1", o_upd_valid, o_upd_cnt, o_req_ready, o_busy);
        end
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        busy_cyc = 0; n_wr = 0; done = 1'b0;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge i_clk);
            if (o_write_en) begin
                n_assert++;
                if (o_addr_w !== AW'(n_wr) || o_data !== '0) begin
                    n_fail++; $display("FAIL mid_sweep_write: got addr %0d data %0d expected addr %0d data 0", o_addr_w, o_data, n_wr);
                end
                n_wr++;
            end
            if (o_busy) busy_cyc++; else done = 1'b1;
        end
        n_assert++; if (!done) begin n_fail++; $display("FAIL mid_sweep_timeout: busy still high after 200 cycles"); end
        n_assert++; if (busy_cyc != 64 || n_wr != 64) begin
            n_fail++; $display("FAIL mid_sweep_len: got busy %0d writes %0d expected 64 and 64", busy_cyc, n_wr);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_wb_forward();
        test_signed();
        test_clear_inflight();
        test_reset_mid_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
